// File: rtl/rx_filt_pkg.sv
// rtl/rx_filt_pkg.sv - shared constants and FSM state type for the RX filter scheduler
//
// Holds the default filter length, the derived centre-tap index, the width
// of the folded tap index and the scheduler state encoding.
package rx_filt_pkg;

  localparam int COEFF_LEN_DEF = 81;
  localparam int HALF_LEN_DEF  = (COEFF_LEN_DEF - 1) / 2;
  localparam int TAP_W         = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DUMP = 2'd2
  } state_t;

endpackage

// File: rtl/rx_sched_tap_cnt.sv
// rtl/rx_sched_tap_cnt.sv - folded tap index counter for the RX filter scheduler
//
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   clear       - synchronous return to tap 0 (wins over inc)
//   inc         - advance to the next tap
//   idx         - current folded tap index (registered)
//   last        - idx is the centre tap
module rx_sched_tap_cnt
  import rx_filt_pkg::*;
#(
  parameter int HALF_LEN = HALF_LEN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [TAP_W-1:0] idx,
  output logic             last
);

  localparam logic [TAP_W-1:0] LAST_IDX = TAP_W'(HALF_LEN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + 1'b1;
    end
  end

  assign last = (idx == LAST_IDX);

endmodule

// File: rtl/rx_filter_sched.sv
// rtl/rx_filter_sched.sv - MAC sequencer for a symmetric (folded) FIR filter
//
// Each accepted sam_clk_en walks the folded taps 0..HALF_LEN, one MAC per
// cycle, then emits a one-cycle dump. Requests arriving mid-run are dropped
// and flagged in the sticky overrun bit.
//
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   sam_clk_en  - request one output sample
//   ovr_clr     - clear overrun (a simultaneous new overrun wins)
//   tap_idx     - folded tap index
//   center      - tap_idx is the centre tap (no pair add)
//   acc_en      - MAC cycle active
//   acc_clr     - first MAC cycle, accumulator loads instead of adds
//   dump        - output register latches the accumulator
//   busy        - RUN or DUMP
//   overrun     - sticky dropped-request flag
// Optional (macro RX_FILTER_SCHED_SYM_PHASE_EN):
//   sym_clk_en  - force sym_phase to 0
//   sym_phase   - dump count modulo 4
//   sym_strobe  - asserted with dump when the pre-increment sym_phase is 0
module rx_filter_sched
  import rx_filt_pkg::*;
#(
  parameter int COEFF_LEN = COEFF_LEN_DEF,
  parameter int HALF_LEN  = (COEFF_LEN - 1) / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sam_clk_en,
  input  logic             ovr_clr,
`ifdef RX_FILTER_SCHED_SYM_PHASE_EN
  input  logic             sym_clk_en,
  output logic [1:0]       sym_phase,
  output logic             sym_strobe,
`endif
  output logic [TAP_W-1:0] tap_idx,
  output logic             center,
  output logic             acc_en,
  output logic             acc_clr,
  output logic             dump,
  output logic             busy,
  output logic             overrun
);

  if (COEFF_LEN < 3 || (COEFF_LEN % 2) == 0 || HALF_LEN >= (1 << TAP_W)) begin : g_bad_coeff_len
    $error("rx_filter_sched: COEFF_LEN must be odd, >= 3 and fit the tap index");
  end

  // Centre flag is registered one tap ahead so it lines up with tap_idx.
  localparam logic [TAP_W-1:0] PRE_LAST_IDX = TAP_W'(HALF_LEN - 1);

  state_t           state;
  logic             cnt_inc;
  logic             cnt_clear;
  logic             cnt_last;
  logic [TAP_W-1:0] cnt_idx;

  // Counter only advances inside RUN; everywhere else it is held at 0.
  assign cnt_inc   = (state == RUN) && !cnt_last;
  assign cnt_clear = !cnt_inc;

  rx_sched_tap_cnt #(
    .HALF_LEN(HALF_LEN)
  ) u_tap_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(cnt_clear),
    .inc  (cnt_inc),
    .idx  (cnt_idx),
    .last (cnt_last)
  );

  assign tap_idx = cnt_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      center  <= 1'b0;
      acc_en  <= 1'b0;
      acc_clr <= 1'b0;
      dump    <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      center  <= 1'b0;
      acc_clr <= 1'b0;
      dump    <= 1'b0;
      case (state)
        IDLE: begin
          if (sam_clk_en) begin
            state   <= RUN;
            acc_en  <= 1'b1;
            acc_clr <= 1'b1;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_last) begin
            state  <= DUMP;
            acc_en <= 1'b0;
            dump   <= 1'b1;
          end else begin
            center <= (cnt_idx == PRE_LAST_IDX);
          end
        end
        DUMP: begin
          if (sam_clk_en) begin
            state   <= RUN;
            acc_en  <= 1'b1;
            acc_clr <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          acc_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase

      // A dropped request sets the flag even when ovr_clr is also high.
      if (sam_clk_en && state == RUN) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef RX_FILTER_SCHED_SYM_PHASE_EN
  // sym_phase advances as the dump cycle ends, so during dump it still shows
  // the pre-increment value that sym_strobe was derived from.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_phase  <= 2'd0;
      sym_strobe <= 1'b0;
    end else begin
      sym_strobe <= (state == RUN) && cnt_last && (sym_phase == 2'd0);
      if (sym_clk_en) begin
        sym_phase <= 2'd0;
      end else if (dump) begin
        sym_phase <= sym_phase + 2'd1;
      end
    end
  end
`endif

endmodule

// File: doc/rx_filter_sched.md
RX_FILTER_SCHED -- requirements
Module: rx_filter_sched

Interface
REQ-001 Parameter COEFF_LEN, default 81: filter length; SHALL be odd and at least 3.
REQ-002 Parameter HALF_LEN, default (COEFF_LEN-1)/2: index of the centre tap; SHALL be derived and not overridden.
REQ-003 Port clk, in, 1: the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset, in, 1: asynchronous, active-low reset.
REQ-005 Port sam_clk_en, in, 1: one-cycle strobe requesting computation of one output sample.
REQ-006 Port ovr_clr, in, 1: synchronous clear of overrun.
REQ-007 Port tap_idx, out, 6: folded tap index; selects coefficient b[tap_idx] and the sample pair x[tap_idx] and x[COEFF_LEN-1-tap_idx].
REQ-008 Port center, out, 1: high when tap_idx==HALF_LEN; the centre sample is used alone, with no pair add.
REQ-009 Port acc_en, out, 1: a MAC cycle is active.
REQ-010 Port acc_clr, out, 1: first MAC cycle; the accumulator loads the product instead of adding it.
REQ-011 Port dump, out, 1: one-cycle strobe; the output register latches the accumulator.
REQ-012 Port busy, out, 1: high in the RUN and DUMP states.
REQ-013 Port overrun, out, 1: sticky flag for a request that was dropped.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN, DUMP.
REQ-015 IDLE: on sam_clk_en, go to RUN with tap_idx=0.
- Otherwise stay in IDLE with tap_idx=0.
REQ-016 RUN: tap_idx SHALL increment by 1 per cycle.
- acc_en=1 throughout RUN.
- acc_clr=1 only when tap_idx=0.
- Go to DUMP after the cycle with tap_idx=HALF_LEN.
REQ-017 DUMP lasts exactly one cycle with dump=1 and acc_en=0.
- With sam_clk_en in that cycle, go directly to RUN with tap_idx=0 (back-to-back operation).
- Otherwise go to IDLE.
REQ-018 Latency: a sam_clk_en sampled at edge t SHALL give:
- tap 0 in cycle t+1;
- tap HALF_LEN in cycle t+1+HALF_LEN;
- dump in cycle t+2+HALF_LEN.
The minimum accepted request spacing is HALF_LEN+2 cycles.
REQ-019 A sam_clk_en that arrives during RUN SHALL be ignored and SHALL set overrun.
- The sequence in progress SHALL complete unchanged.
REQ-020 overrun SHALL stay set until ovr_clr or reset.
- If ovr_clr and a new overrun event occur in the same cycle, the set wins.
REQ-021 All outputs SHALL be registered, and no combinational path SHALL run from any input to any output.
REQ-022 tap_idx SHALL never exceed HALF_LEN.

Reset
REQ-023 While reset=0, the block SHALL asynchronously force:
- state=IDLE;
- tap_idx=0;
- center, acc_en, acc_clr, dump, busy and overrun all 0.
REQ-024 Reset asserted mid-RUN SHALL abort the sequence with no dump; the first request after release SHALL start from tap 0.

Configuration
REQ-025 With macro RX_FILTER_SCHED_SYM_PHASE_EN defined, the block SHALL add:
- port sym_clk_en, in, 1;
- port sym_phase, out, 2, reset value 0;
- port sym_strobe, out, 1.
REQ-026 With the macro defined, each dump SHALL increment sym_phase modulo 4.
- sym_strobe SHALL be asserted together with dump when the pre-increment sym_phase==0.
- sym_clk_en SHALL force sym_phase to 0 on the next edge and takes priority over the increment.
REQ-027 Without the macro, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package rx_filt_pkg SHALL hold:
- COEFF_LEN and HALF_LEN defaults;
- the tap-index width constant;
- the FSM state typedef (IDLE, RUN, DUMP).
REQ-029 The tap counter SHALL be a sub-module named rx_sched_tap_cnt with inputs clear and inc, and outputs idx and last.
- The FSM and flag logic SHALL remain in rx_filter_sched.

Verification
REQ-030 Single request: sam_clk_en at cycle 10 -> acc_clr at cycle 11; tap_idx runs 0..40 over cycles 11..51; center at cycle 51; dump at cycle 52; idle at cycle 53.
REQ-031 Back-to-back: requests at cycles 10 and 52 -> dump at 52, tap 0 at 53, second dump at 94; overrun stays 0.
REQ-032 Overrun: requests at cycles 10 and 30 -> overrun=1 from cycle 31; a single dump at 52; ovr_clr at cycle 60 -> overrun=0 at 61.
REQ-033 Reset mid-run: reset=0 at cycle 25 -> all outputs 0 immediately and no dump ever; a request after release starts at tap 0.
REQ-034 With RX_FILTER_SCHED_SYM_PHASE_EN: 8 spaced requests -> sym_phase sequence 0,1,2,3,0,1,2,3 and sym_strobe on dumps 1 and 5; sym_clk_en before dump 3 -> sym_strobe on dump 3.
REQ-035 Parameter COEFF_LEN=5 -> tap_idx runs 0..2, center on idx 2, dump 4 cycles after the request.
